list_walker: RTL and testbench

Read-port initiator that traverses a Lisp list in the cons heap. Given a head pointer, it fetches each cell's CAR through the memory block's read interface, streams elements out on a ready/valid port, follows CDR links until `LISP_NIL`, and reports element count and termination status. It is the sole master of the memory read port and sits between the evaluator (list consumer) and the heap memory.

---
 rtl/lisp_defs.sv | 21 ++
 rtl/list_walker.sv | 163 ++++++++++++++++
 tb/tb_list_walker.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lisp_defs.sv
// lisp_defs: shared Lisp heap definitions.
//   LISP_NIL   - the empty-list word
//   TYPE_CONS  - type tag (word bits [14:12]) of a cons pointer
//   walk_err_t - termination status reported by list_walker
//   is_cons()  - true when a word is tagged as a cons pointer
package lisp_defs;

    localparam logic [15:0] LISP_NIL  = 16'h0000;
    localparam logic [2:0]  TYPE_CONS = 3'd1;

    typedef enum logic [1:0] {
        WalkOk       = 2'd0,
        WalkImproper = 2'd1,
        WalkLimit    = 2'd2
    } walk_err_t;

    function automatic logic is_cons(input logic [15:0] word);
        return word[14:12] == TYPE_CONS;
    endfunction

endpackage

// File: rtl/list_walker.sv
// list_walker: walks a Lisp list in the cons heap and streams its CARs.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start, head       - request to walk the list at 'head' (accepted in Idle)
//   busy, done        - walk in progress / one-cycle completion pulse
//   err, count        - termination status and element count, held after done
//   elem_valid/ready  - element stream handshake, elem_data is the CAR word
//   mem_req, mem_addr - single-cycle read request and its address
//   mem_data_ready    - read data valid, mem_data is the read word
//
// Handshakes: an element transfers on a cycle where elem_valid and
// elem_ready are both high; elem_valid stays high with elem_data stable until
// then. A memory read is one mem_req pulse; the walker then holds mem_addr and
// waits any number of cycles for mem_data_ready, which is ignored elsewhere.
//
// Cell layout: CAR at addr, CDR at addr - 1 (modulo 4096).
module list_walker
    import lisp_defs::*;
#(
    parameter int MaxSteps = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] head,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [11:0] count,
    output logic        elem_valid,
    input  logic        elem_ready,
    output logic [15:0] elem_data,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_data_ready,
    input  logic [15:0] mem_data
);

    // count is 12 bits wide, so the limit has to fit.
    localparam logic [11:0] MAX_COUNT = 12'(MaxSteps);

    typedef enum logic [2:0] {
        Idle    = 3'd0,
        ReqCar  = 3'd1,
        WaitCar = 3'd2,
        Emit    = 3'd3,
        ReqCdr  = 3'd4,
        WaitCdr = 3'd5,
        Finish  = 3'd6
    } state_t;

    state_t      state, state_n;
    logic [11:0] ptr, ptr_n;          // address of the current cell's CAR
    logic [11:0] count_q, count_n;
    walk_err_t   err_q, err_n;
    logic [15:0] data_q, data_n;
    logic [11:0] addr_q, addr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= Idle;
            ptr     <= '0;
            count_q <= '0;
            err_q   <= WalkOk;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            count_q <= count_n;
            err_q   <= err_n;
            data_q  <= data_n;
            addr_q  <= addr_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        count_n = count_q;
        err_n   = err_q;
        data_n  = data_q;
        addr_n  = addr_q;

        case (state)
            Idle: begin
                if (start) begin
                    ptr_n   = head[11:0];
                    count_n = '0;
                    err_n   = WalkOk;
                    if (head == LISP_NIL) begin
                        state_n = Finish;
                    end else if (!is_cons(head)) begin
                        err_n   = WalkImproper;
                        state_n = Finish;
                    end else begin
                        // Address is registered one cycle early so it is
                        // already valid during the request cycle.
                        addr_n  = head[11:0];
                        state_n = ReqCar;
                    end
                end
            end

            ReqCar: state_n = WaitCar;

            WaitCar: begin
                if (mem_data_ready) begin
                    data_n  = mem_data;
                    state_n = Emit;
                end
            end

            Emit: begin
                if (elem_ready) begin
                    count_n = count_q + 12'd1;
                    if (count_n == MAX_COUNT) begin
                        // Circular-list guard: stop without reading the CDR.
                        err_n   = WalkLimit;
                        state_n = Finish;
                    end else begin
                        addr_n  = ptr - 12'd1;
                        state_n = ReqCdr;
                    end
                end
            end

            ReqCdr: state_n = WaitCdr;

            WaitCdr: begin
                if (mem_data_ready) begin
                    if (mem_data == LISP_NIL) begin
                        state_n = Finish;
                    end else if (is_cons(mem_data)) begin
                        ptr_n   = mem_data[11:0];
                        addr_n  = mem_data[11:0];
                        state_n = ReqCar;
                    end else begin
                        err_n   = WalkImproper;
                        state_n = Finish;
                    end
                end
            end

            Finish: state_n = Idle;

            default: state_n = Idle;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    assign busy       = (state != Idle) && (state != Finish);
    assign done       = (state == Finish);
    assign elem_valid = (state == Emit);
    assign mem_req    = (state == ReqCar) || (state == ReqCdr);

    assign err        = err_q;
    assign count      = count_q;
    assign elem_data  = data_q;
    assign mem_addr   = addr_q;

endmodule

// File: tb/tb_list_walker.sv
// tb_list_walker: self-checking bench for list_walker.
// The bench plays the heap memory (configurable latency, optional stray
// mem_data_ready pulses) and the element consumer (optional back-pressure),
// and compares every walk with a list-level reference model.
module tb_list_walker;
    import lisp_defs::*;

    localparam int MAX_STEPS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] head = '0;
    logic        busy, done;
    logic [1:0]  err;
    logic [11:0] count;
    logic        elem_valid;
    logic        elem_ready = 1'b1;
    logic [15:0] elem_data;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_data_ready = 1'b0;
    logic [15:0] mem_data = '0;

    list_walker #(.MaxSteps(MAX_STEPS)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .head           (head),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .count          (count),
        .elem_valid     (elem_valid),
        .elem_ready     (elem_ready),
        .elem_data      (elem_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data_ready (mem_data_ready),
        .mem_data       (mem_data)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- shared bench state ----------------
    logic [15:0] mem [4096];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int  checks = 0;
    int  passes = 0;
    int  lat = 1;
    bit  stall = 1'b0;
    bit  noise = 1'b0;
    int  req_count = 0;

    // ---------------- memory + consumer driver ----------------
    initial begin : responder
        logic [11:0] a;
        int cnt;
        int hold;
        a = '0;
        cnt = 0;
        hold = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_data_ready = 1'b0;
            if (rst) begin
                cnt = 0;
                hold = 0;
            end else begin
                if (cnt > 0) begin
                    checks++;
                    if (mem_addr !== a || mem_req !== 1'b0)
                        $display("FAIL mem_addr_hold: addr=%h req=%b, expected addr=%h req=0",
                                 mem_addr, mem_req, a);
                    else
                        passes++;
                    cnt--;
                    if (cnt == 0) begin
                        mem_data_ready = 1'b1;
                        mem_data = mem[a];
                    end
                end else if (mem_req === 1'b1) begin
                    a = mem_addr;
                    cnt = lat;
                    req_count++;
                end else if (noise && $urandom_range(0, 3) == 0) begin
                    mem_data_ready = 1'b1;
                    mem_data = 16'($urandom);
                end
            end
            if (stall && elem_valid === 1'b1 && hold < 3) begin
                elem_ready = 1'b0;
                hold++;
            end else begin
                elem_ready = 1'b1;
                if (elem_valid !== 1'b1) hold = 0;
            end
        end
    end

    // ---------------- element monitor ----------------
    initial begin : monitor
        logic [15:0] prev;
        bit waiting;
        prev = '0;
        waiting = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                waiting = 1'b0;
            end else if (elem_valid === 1'b1) begin
                if (waiting) begin
                    checks++;
                    if (elem_data !== prev)
                        $display("FAIL elem_stable: data=%h, expected %h", elem_data, prev);
                    else
                        passes++;
                end
                if (elem_ready) got_q.push_back(elem_data);
                waiting = !elem_ready;
                prev = elem_data;
            end else begin
                waiting = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    // Follows the list in the bench's heap image: emits CARs, stops on NIL,
    // on a non-cons link, or when MAX_STEPS elements have been emitted.
    task automatic model(input logic [15:0] h, output int n, output logic [1:0] e);
        logic [15:0] p;
        logic [11:0] cdr_a;
        exp_q.delete();
        n = 0;
        e = 2'd0;
        p = h;
        if (p == LISP_NIL) return;
        if (p[14:12] != TYPE_CONS) begin
            e = 2'd1;
            return;
        end
        while (1) begin
            exp_q.push_back(mem[p[11:0]]);
            n++;
            if (n == MAX_STEPS) begin
                e = 2'd2;
                return;
            end
            cdr_a = p[11:0] - 12'd1;
            p = mem[cdr_a];
            if (p == LISP_NIL) return;
            if (p[14:12] != TYPE_CONS) begin
                e = 2'd1;
                return;
            end
        end
    endtask

    // ---------------- one walk, fully checked ----------------
    // Entered and left at posedge+1. start is driven in the cycle after edge 0;
    // 'k' is the edge after which done is first seen, so done is sampled high
    // at edge k+1.
    task automatic run_walk(input logic [15:0] h, input bit timed, input bit stray,
                            input string name);
        int n_exp;
        logic [1:0] e_exp;
        int k;
        bit busy_ok;
        int exp_cycles;
        int exp_reqs;
        int n_cmp;

        model(h, n_exp, e_exp);
        got_q.delete();
        req_count = 0;
        head = h;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        head = 16'($urandom);
        k = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && k < 3000) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (stray && k == 6) begin
                start = 1'b1;
                head = 16'h1000 | 16'($urandom_range(0, 4095));
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;

        checks++;
        if (done !== 1'b1) begin
            $display("FAIL %s timeout: done=%b after %0d cycles, expected 1", name, done, k);
            return;
        end
        passes++;

        checks++;
        if (err !== e_exp) $display("FAIL %s err: got %0d, expected %0d", name, err, e_exp);
        else passes++;

        checks++;
        if (count !== 12'(n_exp))
            $display("FAIL %s count: got %0d, expected %0d", name, count, n_exp);
        else passes++;

        checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL %s elem_count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
        else passes++;

        n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL %s elem[%0d]: got %h, expected %h", name, i, got_q[i], exp_q[i]);
            else passes++;
        end

        exp_reqs = (e_exp == 2'd2) ? 2 * n_exp - 1 : 2 * n_exp;
        checks++;
        if (req_count != exp_reqs)
            $display("FAIL %s mem_req_pulses: got %0d, expected %0d", name, req_count, exp_reqs);
        else passes++;

        checks++;
        if (busy !== 1'b0 || !busy_ok)
            $display("FAIL %s busy: at_done=%b held_while_walking=%b, expected 0 and 1",
                     name, busy, busy_ok);
        else passes++;

        if (timed) begin
            // Five cycles per element; a limit stop skips ReqCdr/WaitCdr of the
            // last element and the final CDR evaluation.
            exp_cycles = (e_exp == 2'd2) ? 5 * n_exp : 5 * n_exp + 2;
            checks++;
            if (k + 1 != exp_cycles)
                $display("FAIL %s done_latency: got %0d, expected %0d", name, k + 1, exp_cycles);
            else passes++;
        end

        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || err !== e_exp || count !== 12'(n_exp))
            $display("FAIL %s after_done: done=%b err=%0d count=%0d, expected 0/%0d/%0d",
                     name, done, err, count, e_exp, n_exp);
        else passes++;
    endtask

    // ---------------- scenarios ----------------
    task automatic check_all_zero(input string name);
        checks++;
        if ({busy, done, elem_valid, mem_req} !== 4'b0)
            $display("FAIL %s flags: busy/done/elem_valid/mem_req=%b, expected 0000",
                     name, {busy, done, elem_valid, mem_req});
        else passes++;
        checks++;
        if (err !== 2'd0 || count !== 12'd0)
            $display("FAIL %s status: err=%0d count=%0d, expected 0/0", name, err, count);
        else passes++;
        checks++;
        if (elem_data !== 16'd0 || mem_addr !== 12'd0)
            $display("FAIL %s data: elem_data=%h mem_addr=%h, expected 0/0", name, elem_data, mem_addr);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_elem();
        mem[5] = LISP_NIL;
        mem[6] = 16'h00AA;
        mem[7] = 16'h1006;
        mem[8] = 16'h00BB;
        run_walk(16'h1008, 1'b1, 1'b0, "two_elem");
    endtask

    task automatic test_improper_cdr();
        mem[3] = 16'h0001;
        mem[4] = 16'h0002;
        run_walk(16'h1004, 1'b1, 1'b0, "improper_cdr");
    endtask

    task automatic test_non_list_head();
        run_walk(LISP_NIL, 1'b1, 1'b0, "nil_head");
        run_walk(16'h2004, 1'b1, 1'b0, "atom_head");
    endtask

    task automatic test_self_loop();
        mem[9]  = 16'h100A;
        mem[10] = 16'h0055;
        run_walk(16'h100A, 1'b1, 1'b0, "self_loop");
    endtask

    task automatic test_wrap();
        mem[0]     = 16'h0077;
        mem[12'hFFF] = LISP_NIL;
        run_walk(16'h1000, 1'b1, 1'b0, "cdr_wrap");
    endtask

    task automatic test_stall_latency();
        lat = 3;
        stall = 1'b1;
        run_walk(16'h1008, 1'b0, 1'b1, "stall_latency");
        lat = 1;
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_walk();
        int k;
        bit no_done;
        lat = 3;
        got_q.delete();
        head = 16'h1008;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (got_q.size() < 1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (got_q.size() < 1) begin
            $display("FAIL reset_mid_walk first_elem: got %0d elements, expected 1", got_q.size());
        end else begin
            passes++;
        end
        // Now in ReqCdr; one more edge puts the walker in WaitCdr.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_walk");
        @(posedge clk);
        #1;
        rst = 1'b0;
        no_done = 1'b1;
        repeat (8) begin
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!no_done) $display("FAIL reset_mid_walk idle: done/busy seen after reset, expected 0");
        else passes++;
        run_walk(16'h1008, 1'b0, 1'b0, "after_reset");
        lat = 1;
    endtask

    task automatic test_random();
        logic [11:0] a [6];
        logic [11:0] cdr_a;
        logic [15:0] h;
        int len;
        int term;
        int mode;
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) a[i] = 12'($urandom);
            for (int i = 0; i < len; i++) begin
                mem[a[i]] = 16'($urandom);
                cdr_a = a[i] - 12'd1;
                if (i < len - 1) begin
                    mem[cdr_a] = {1'b0, TYPE_CONS, a[i + 1]};
                end else begin
                    term = $urandom_range(0, 2);
                    if (term == 0)      mem[cdr_a] = LISP_NIL;
                    else if (term == 1) mem[cdr_a] = {1'b0, 3'($urandom_range(2, 7)), 12'($urandom)};
                    else                mem[cdr_a] = {1'b0, TYPE_CONS, a[0]};
                end
            end
            mode = $urandom_range(0, 9);
            if (mode == 0)      h = LISP_NIL;
            else if (mode == 1) h = {1'b0, 3'($urandom_range(2, 7)), 12'($urandom)};
            else                h = {1'b0, TYPE_CONS, a[0]};
            lat = $urandom_range(1, 4);
            stall = 1'($urandom_range(0, 1));
            noise = 1'b1;
            run_walk(h, (lat == 1) && !stall, 1'b0, $sformatf("random%0d", t));
        end
        lat = 1;
        stall = 1'b0;
        noise = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        test_reset();
        test_two_elem();
        test_improper_cdr();
        test_non_list_head();
        test_self_loop();
        test_wrap();
        test_stall_latency();
        test_reset_mid_walk();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
